// File: rtl/fp_stage_pkg.sv
// Shared widths and the operand bundle type for the FP elastic stage.
package fp_stage_pkg;

    localparam int unsigned FP_N  = 32;
    localparam int unsigned FP_MW = 23;

    typedef struct packed {
        logic [FP_N-1:0]  x;
        logic [FP_N-1:0]  y;
        logic [FP_MW-1:0] man;
    } fp_bundle_t;

endpackage

// File: rtl/fp_elastic_ctrl.sv
// Pointer, occupancy and handshake control for the FP elastic stage.
module fp_elastic_ctrl #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic                         out_ready,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic                         push_c,
    output logic [$clog2(DEPTH)-1:0]     wr_ptr,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          pop_c;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;

    // Handshake decode; a flush swallows both transfers of its cycle.
    always_comb begin
        push_c = in_valid & in_ready & ~flush;
        pop_c  = out_valid & out_ready & ~flush;
    end

    // Next pointer/occupancy state; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push_c) wr_ptr_next = wr_ptr + PW'(1);
            if (pop_c)  rd_ptr_next = rd_ptr + PW'(1);
            unique case ({push_c, pop_c})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // State register; ready/valid are flopped from the next occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            in_ready  <= (count_next != CW'(DEPTH));
            out_valid <= (count_next != CW'(0));
        end
    end

endmodule

// File: rtl/fp_elastic_stage.sv
// Elastic valid/ready buffer stage for FP operand bundles (X, Y, mantissa).
module fp_elastic_stage
    import fp_stage_pkg::*;
#(
    parameter int unsigned N     = FP_N,
    parameter int unsigned MW    = FP_MW,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N-1:0]               in_x,
    input  logic [N-1:0]               in_y,
    input  logic [MW-1:0]              in_man,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_x,
    output logic [N-1:0]               out_y,
    output logic [MW-1:0]              out_man,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [N-1:0]  x_mem   [DEPTH];
    logic [N-1:0]  y_mem   [DEPTH];
    logic [MW-1:0] man_mem [DEPTH];

    logic          push_c;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    fp_elastic_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .push_c    (push_c),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Bundle storage, written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                x_mem[i]   <= '0;
                y_mem[i]   <= '0;
                man_mem[i] <= '0;
            end
        end else if (push_c) begin
            x_mem[wr_ptr]   <= in_x;
            y_mem[wr_ptr]   <= in_y;
            man_mem[wr_ptr] <= in_man;
        end
    end

    // Head bundle is read straight out of the storage registers.
    always_comb begin
        out_x   = x_mem[rd_ptr];
        out_y   = y_mem[rd_ptr];
        out_man = man_mem[rd_ptr];
    end

endmodule

// File: tb/tb_fp_elastic_stage.sv
// Directed bench for fp_elastic_stage: DEPTH=2 vector table plus DEPTH=4 wrap sequence.
module tb_fp_elastic_stage;
    import fp_stage_pkg::*;

    logic clk;
    logic reset;

    // DEPTH=2 instance signals
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_x, a_in_y, a_out_x, a_out_y;
    logic [22:0] a_in_man, a_out_man;
    logic [1:0]  a_count;

    // DEPTH=4 instance signals
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_x, b_in_y, b_out_x, b_out_y;
    logic [22:0] b_in_man, b_out_man;
    logic [2:0]  b_count;

    int checks   = 0;
    int failures = 0;

    fp_elastic_stage #(.N(32), .MW(23), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_x(a_in_x), .in_y(a_in_y), .in_man(a_in_man),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_x(a_out_x), .out_y(a_out_y), .out_man(a_out_man),
        .count(a_count)
    );

    fp_elastic_stage #(.N(32), .MW(23), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_x(b_in_x), .in_y(b_in_y), .in_man(b_in_man),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_x(b_out_x), .out_y(b_out_y), .out_man(b_out_man),
        .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic       in_valid;
        logic       out_ready;
        fp_bundle_t d;
        logic       e_ov;
        logic       e_ir;
        logic [1:0] e_cnt;
        logic       e_chk;
        fp_bundle_t e_d;
    } vec_t;

    function automatic fp_bundle_t mk(input logic [31:0] x, input logic [31:0] y,
                                      input logic [22:0] m);
        fp_bundle_t b;
        b.x = x; b.y = y; b.man = m;
        return b;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic fp_bundle_t a_out();
        return mk(a_out_x, a_out_y, a_out_man);
    endfunction

    function automatic fp_bundle_t b_out();
        return mk(b_out_x, b_out_y, b_out_man);
    endfunction

    vec_t       vt[14];
    fp_bundle_t z, A, B, C, D, E, F, G, H, I, J, K;
    fp_bundle_t q[$];
    int         id;
    logic       exp_ir, do_push;

    initial begin
        z = mk(32'h0, 32'h0, 23'h0);
        A = mk(32'h3F800000, 32'h40000000, 23'h400000);
        B = mk(32'h11111111, 32'h22222222, 23'h333333);
        C = mk(32'h44444444, 32'h55555555, 23'h666666);
        D = mk(32'h77777777, 32'h88888888, 23'h199999);
        E = mk(32'hAAAAAAAA, 32'hBBBBBBBB, 23'h2CCCCC);
        F = mk(32'hDDDDDDDD, 32'hEEEEEEEE, 23'h0FFFFF);
        G = mk(32'h12345678, 32'h9ABCDEF0, 23'h123456);
        H = mk(32'hCAFEBABE, 32'hDEADBEEF, 23'h7EDCBA);
        I = mk(32'h0BADF00D, 32'hFEEDFACE, 23'h0ABCDE);
        J = mk(32'h13579BDF, 32'h2468ACE0, 23'h55AA55);

        // flush, in_valid, out_ready, data, exp ov, ir, cnt, check data, exp data
        vt[0]  = '{1'b0, 1'b1, 1'b1, A, 1'b1, 1'b1, 2'd1, 1'b1, A}; // push A
        vt[1]  = '{1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, 2'd0, 1'b0, z}; // pop A
        vt[2]  = '{1'b0, 1'b1, 1'b0, B, 1'b1, 1'b1, 2'd1, 1'b1, B}; // stalled push B
        vt[3]  = '{1'b0, 1'b1, 1'b0, C, 1'b1, 1'b0, 2'd2, 1'b1, B}; // push C -> full
        vt[4]  = '{1'b0, 1'b1, 1'b0, D, 1'b1, 1'b0, 2'd2, 1'b1, B}; // D rejected
        vt[5]  = '{1'b0, 1'b0, 1'b1, z, 1'b1, 1'b1, 2'd1, 1'b1, C}; // pop B
        vt[6]  = '{1'b0, 1'b1, 1'b1, E, 1'b1, 1'b1, 2'd1, 1'b1, E}; // push E + pop C
        vt[7]  = '{1'b0, 1'b1, 1'b0, F, 1'b1, 1'b0, 2'd2, 1'b1, E}; // push F -> full
        vt[8]  = '{1'b1, 1'b1, 1'b1, G, 1'b0, 1'b1, 2'd0, 1'b0, z}; // flush at count 2
        vt[9]  = '{1'b0, 1'b1, 1'b0, H, 1'b1, 1'b1, 2'd1, 1'b1, H}; // push H
        vt[10] = '{1'b1, 1'b1, 1'b0, I, 1'b0, 1'b1, 2'd0, 1'b0, z}; // flush drops I
        vt[11] = '{1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, 2'd0, 1'b0, z}; // idle, I never shows
        vt[12] = '{1'b0, 1'b1, 1'b0, J, 1'b1, 1'b1, 2'd1, 1'b1, J}; // push J
        vt[13] = '{1'b0, 1'b0, 1'b1, z, 1'b0, 1'b1, 2'd0, 1'b0, z}; // pop J

        reset = 1'b0;
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_x = '0; a_in_y = '0; a_in_man = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_x = '0; b_in_y = '0; b_in_man = '0;

        #13;
        chk("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
        chk("rst_in_ready",  128'(a_in_ready),  128'(1'b1));
        chk("rst_count",     128'(a_count),     128'(2'd0));
        chk("rst_data",      128'(a_out()),     128'(z));
        #10 reset = 1'b1;
        step();

        // DEPTH=2 vector table
        foreach (vt[k]) begin
            a_flush     = vt[k].flush;
            a_in_valid  = vt[k].in_valid;
            a_out_ready = vt[k].out_ready;
            a_in_x      = vt[k].d.x;
            a_in_y      = vt[k].d.y;
            a_in_man    = vt[k].d.man;
            step();
            chk($sformatf("vec%0d_out_valid", k), 128'(a_out_valid), 128'(vt[k].e_ov));
            chk($sformatf("vec%0d_in_ready", k),  128'(a_in_ready),  128'(vt[k].e_ir));
            chk($sformatf("vec%0d_count", k),     128'(a_count),     128'(vt[k].e_cnt));
            if (vt[k].e_chk)
                chk($sformatf("vec%0d_data", k), 128'(a_out()), 128'(vt[k].e_d));
        end
        a_flush = 1'b0;

        // Sustained 1-per-cycle flow: each cycle pops the previous and pushes the next
        for (int i = 0; i < 8; i++) begin
            K = mk(32'h40400000 + 32'(i), 32'hC0000000 ^ 32'(i * 7), 23'(i * 3 + 1));
            a_in_valid = 1'b1; a_out_ready = 1'b1;
            a_in_x = K.x; a_in_y = K.y; a_in_man = K.man;
            step();
            chk($sformatf("flow%0d_count", i), 128'(a_count),   128'(2'd1));
            chk($sformatf("flow%0d_valid", i), 128'(a_out_valid), 128'(1'b1));
            chk($sformatf("flow%0d_data", i),  128'(a_out()),   128'(K));
        end
        a_in_valid = 1'b0;
        step();
        chk("flow_drain_count", 128'(a_count), 128'(2'd0));

        // DEPTH=4: fill, steady push/pop across pointer wrap, drain; scoreboard order check
        id = 0;
        for (int cyc = 0; cyc < 22; cyc++) begin
            K = mk(32'hA0000000 + 32'(id), ~(32'hA0000000 + 32'(id)), 23'(id + 5));
            b_in_valid  = (cyc < 16);
            b_out_ready = (cyc >= 5);
            b_in_x = K.x; b_in_y = K.y; b_in_man = K.man;
            exp_ir  = (q.size() != 4);
            do_push = b_in_valid && exp_ir;
            chk($sformatf("d4_c%0d_in_ready", cyc), 128'(b_in_ready), 128'(exp_ir));
            chk($sformatf("d4_c%0d_count", cyc),    128'(b_count),    128'(q.size()));
            if (b_out_ready && q.size() > 0) begin
                chk($sformatf("d4_c%0d_valid", cyc), 128'(b_out_valid), 128'(1'b1));
                chk($sformatf("d4_c%0d_data", cyc),  128'(b_out()),     128'(q[0]));
                void'(q.pop_front());
            end
            if (do_push) begin
                q.push_back(K);
                id++;
            end
            step();
        end
        chk("d4_final_count", 128'(b_count), 128'(q.size()));
        chk("d4_pushed_enough", 128'(id >= 10), 128'(1'b1));
        b_in_valid = 1'b0; b_out_ready = 1'b0;

        // Mid-traffic async reset
        a_in_valid = 1'b1; a_out_ready = 1'b0;
        a_in_x = A.x; a_in_y = A.y; a_in_man = A.man;
        b_in_valid = 1'b1;
        b_in_x = B.x; b_in_y = B.y; b_in_man = B.man;
        step();
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        chk("pre_rst_count", 128'(a_count), 128'(2'd1));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 128'(a_out_valid), 128'(1'b0));
        chk("mid_rst_in_ready",  128'(a_in_ready),  128'(1'b1));
        chk("mid_rst_count",     128'(a_count),     128'(2'd0));
        chk("mid_rst_data",      128'(a_out()),     128'(z));
        chk("mid_rst_d4_count",  128'(b_count),     128'(3'd0));
        chk("mid_rst_d4_data",   128'(b_out()),     128'(z));
        #2 reset = 1'b1;
        step();
        chk("post_rst_count", 128'(a_count), 128'(2'd0));
        chk("post_rst_valid", 128'(a_out_valid), 128'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
